// File: rtl/selector_pkg.sv
// Shared types and helpers for the registered one-hot selector with scan sequencing.
package selector_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_LOOP   = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic int unsigned onehot_width(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/selector_predecode.sv
// Binary-to-one-hot predecoder for one address field; purely combinational.
module selector_predecode #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0]    bin,
  output logic [2**W-1:0] dec
);

  always_comb begin
    dec      = '0;
    dec[bin] = 1'b1;
  end

endmodule

// File: rtl/selector_scan.sv
// Registered one-hot selector: accepts a single/scan/loop command and steps the
// selected address with a per-address dwell, decoding through a hi/lo AND matrix.
module selector_scan
  import selector_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LO_W    = 4,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [1:0]                         cmd_mode,
  input  logic [ADDR_W-1:0]                  cmd_start,
  input  logic [ADDR_W-1:0]                  cmd_end,
  input  logic [DWELL_W-1:0]                 cmd_dwell,
  input  logic                               abort,
  output logic [onehot_width(ADDR_W)-1:0]    sel_onehot,
  output logic [ADDR_W-1:0]                  sel_addr,
  output logic                               sel_valid,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned SEL_W = onehot_width(ADDR_W);
  localparam int unsigned HI_W  = ADDR_W - LO_W;
  localparam int unsigned LO_N  = 2**LO_W;
  localparam int unsigned HI_N  = 2**HI_W;

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [ADDR_W-1:0]    start_q, start_d;
  logic [ADDR_W-1:0]    end_q, end_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [SEL_W-1:0]     onehot_q, onehot_d;
  logic [LO_N-1:0]      lo_dec;
  logic [HI_N-1:0]      hi_dec;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    start_d = start_q;
    end_d   = end_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = ACTIVE;
          mode_d  = mode_e'(cmd_mode);
          start_d = cmd_start;
          end_d   = cmd_end;
          dwell_d = cmd_dwell;
          cnt_d   = cmd_dwell;
          addr_d  = cmd_start;
          valid_d = 1'b1;
        end
      end
      ACTIVE: begin
        // abort outranks both dwell countdown and completion
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          addr_d  = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (mode_q == MODE_SINGLE ||
                     (mode_q != MODE_LOOP && addr_q == end_q)) begin
          state_d = IDLE;
          valid_d = 1'b0;
          addr_d  = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = dwell_q;
          if (mode_q == MODE_LOOP && addr_q == end_q) begin
            addr_d = start_q;
          end else if (mode_q == MODE_DOWN) begin
            addr_d = addr_q - ADDR_W'(1);
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ACTIVE);
  end

  selector_predecode #(.W(LO_W)) u_lo_dec (
    .bin (addr_d[LO_W-1:0]),
    .dec (lo_dec)
  );

  selector_predecode #(.W(HI_W)) u_hi_dec (
    .bin (addr_d[ADDR_W-1:LO_W]),
    .dec (hi_dec)
  );

  // Output bit {hi,lo} is the AND of the two field decodes, gated by next-valid.
  for (genvar g = 0; g < SEL_W; g++) begin : g_matrix
    assign onehot_d[g] = valid_d & hi_dec[g / LO_N] & lo_dec[g % LO_N];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= MODE_SINGLE;
      start_q  <= '0;
      end_q    <= '0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      start_q  <= start_d;
      end_q    <= end_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      onehot_q <= onehot_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign sel_onehot = onehot_q;
  assign sel_addr   = addr_q;
  assign sel_valid  = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_selector_scan.sv
// Directed table plus hand sequences on the 8/4 build, and a random sweep on 4/2 and 10/5 builds.
module tb_selector_scan;
  import selector_pkg::*;

  localparam int CW = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, cmd_valid, abort, cmd_ready, sel_valid, busy, done;
  logic [1:0]   cmd_mode;
  logic [7:0]   cmd_start, cmd_end, cmd_dwell, sel_addr;
  logic [255:0] sel_onehot;

  selector_scan #(.ADDR_W(8), .LO_W(4), .DWELL_W(8)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_start(cmd_start), .cmd_end(cmd_end),
    .cmd_dwell(cmd_dwell), .abort(abort), .sel_onehot(sel_onehot),
    .sel_addr(sel_addr), .sel_valid(sel_valid), .busy(busy), .done(done)
  );

  logic          sw_valid, sw_abort, r4, r10, v4, v10, b4, b10, d4, d10;
  logic [1:0]    sw_mode;
  logic [7:0]    sw_dwell;
  logic [3:0]    s4, e4, a4;
  logic [9:0]    s10, e10, a10;
  logic [15:0]   oh4;
  logic [1023:0] oh10;

  selector_scan #(.ADDR_W(4), .LO_W(2), .DWELL_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .cmd_valid(sw_valid), .cmd_ready(r4),
    .cmd_mode(sw_mode), .cmd_start(s4), .cmd_end(e4),
    .cmd_dwell(sw_dwell), .abort(sw_abort), .sel_onehot(oh4),
    .sel_addr(a4), .sel_valid(v4), .busy(b4), .done(d4)
  );

  selector_scan #(.ADDR_W(10), .LO_W(5), .DWELL_W(8)) u_dut10 (
    .clk(clk), .rst(rst), .cmd_valid(sw_valid), .cmd_ready(r10),
    .cmd_mode(sw_mode), .cmd_start(s10), .cmd_end(e10),
    .cmd_dwell(sw_dwell), .abort(sw_abort), .sel_onehot(oh10),
    .sel_addr(a10), .sel_valid(v10), .busy(b10), .done(d10)
  );

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic ev, input logic [7:0] ea, input logic ed);
    logic [255:0] eoh;
    eoh = '0;
    if (ev) eoh[ea] = 1'b1;
    chk({tag, " valid"}, CW'(sel_valid), CW'(ev));
    if (ev) chk({tag, " addr"}, CW'(sel_addr), CW'(ea));
    chk({tag, " onehot"}, CW'(sel_onehot), CW'(eoh));
    chk({tag, " busy"}, CW'(busy), CW'(ev));
    chk({tag, " ready"}, CW'(cmd_ready), CW'(!ev));
    chk({tag, " done"}, CW'(done), CW'(ed));
  endtask

  // Called at a negedge; returns at the negedge where the first address is visible.
  task automatic issue(input logic [1:0] m, input logic [7:0] st, input logic [7:0] en, input logic [7:0] dw);
    cmd_mode = m; cmd_start = st; cmd_end = en; cmd_dwell = dw; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  typedef struct packed {
    logic [1:0]  mode;
    logic [7:0]  st;
    logic [7:0]  en;
    logic [7:0]  dw;
    logic [3:0]  len;
    logic [63:0] exp;
  } vec_t;

  vec_t vec [6];

  int unsigned exp_seq [2][32];
  int unsigned len [2];
  int unsigned idx [2];
  logic        fin [2];

  initial begin
    vec[0] = '{MODE_SINGLE, 8'hA5, 8'h00, 8'd2, 4'd3, 64'hA5A5A5_0000000000};
    vec[1] = '{MODE_UP,     8'hFE, 8'h01, 8'd0, 4'd4, 64'hFEFF0001_00000000};
    vec[2] = '{MODE_DOWN,   8'h03, 8'h03, 8'd1, 4'd2, 64'h0303_000000000000};
    vec[3] = '{MODE_DOWN,   8'h02, 8'hFF, 8'd0, 4'd4, 64'h020100FF_00000000};
    vec[4] = '{MODE_UP,     8'h10, 8'h12, 8'd1, 4'd6, 64'h101011111212_0000};
    vec[5] = '{MODE_SINGLE, 8'h00, 8'h77, 8'd0, 4'd1, 64'h00_00000000000000};

    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; cmd_mode = '0;
    cmd_start = '0; cmd_end = '0; cmd_dwell = '0;
    sw_valid = 1'b0; sw_abort = 1'b0; sw_mode = '0; sw_dwell = '0;
    s4 = '0; e4 = '0; s10 = '0; e10 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_main("reset", 1'b0, 8'h00, 1'b0);
    chk("reset addr", CW'(sel_addr), '0);

    for (int i = 0; i < 6; i++) begin
      issue(vec[i].mode, vec[i].st, vec[i].en, vec[i].dw);
      for (int j = 0; j < int'(vec[i].len); j++) begin
        chk_main($sformatf("vec%0d step%0d", i, j), 1'b1, 8'(vec[i].exp >> (56 - 8 * j)), 1'b0);
        @(negedge clk);
      end
      chk_main($sformatf("vec%0d done", i), 1'b0, 8'h00, 1'b1);
      @(negedge clk);
      chk_main($sformatf("vec%0d idle", i), 1'b0, 8'h00, 1'b0);
    end

    // LOOP with an ignored mid-scan command, then abort at 0x11.
    issue(MODE_LOOP, 8'h10, 8'h12, 8'd0);
    chk_main("loop 10", 1'b1, 8'h10, 1'b0);
    @(negedge clk);
    chk_main("loop 11", 1'b1, 8'h11, 1'b0);
    cmd_mode = MODE_SINGLE; cmd_start = 8'h80; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk_main("loop 12 ignore cmd", 1'b1, 8'h12, 1'b0);
    @(negedge clk);
    chk_main("loop wrap 10", 1'b1, 8'h10, 1'b0);
    @(negedge clk);
    chk_main("loop 11 again", 1'b1, 8'h11, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_main("loop abort", 1'b0, 8'h00, 1'b0);
    chk("loop abort addr", CW'(sel_addr), '0);
    @(negedge clk);
    chk_main("loop abort no done", 1'b0, 8'h00, 1'b0);

    // New command accepted in the done cycle.
    issue(MODE_SINGLE, 8'h20, 8'h00, 8'd0);
    chk_main("b2b first", 1'b1, 8'h20, 1'b0);
    @(negedge clk);
    chk_main("b2b done", 1'b0, 8'h00, 1'b1);
    issue(MODE_SINGLE, 8'h21, 8'h00, 8'd0);
    chk_main("b2b second", 1'b1, 8'h21, 1'b0);
    @(negedge clk);
    chk_main("b2b second done", 1'b0, 8'h00, 1'b1);
    @(negedge clk);

    // Abort on the completing cycle wins: no done.
    issue(MODE_SINGLE, 8'h40, 8'h00, 8'd0);
    chk_main("prio addr", 1'b1, 8'h40, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_main("prio abort", 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk_main("prio after", 1'b0, 8'h00, 1'b0);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_main("idle abort", 1'b0, 8'h00, 1'b0);

    // Reset while active at 0x37.
    issue(MODE_UP, 8'h37, 8'h40, 8'd5);
    chk_main("rst active", 1'b1, 8'h37, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_main("rst clear", 1'b0, 8'h00, 1'b0);
    chk("rst clear addr", CW'(sel_addr), '0);

    // Random sweep on the two alternate builds.
    for (int n = 0; n < 20; n++) begin
      int unsigned m;
      m = $urandom_range(0, 2);
      sw_mode  = 2'(m);
      sw_dwell = 8'($urandom_range(0, 2));
      for (int k = 0; k < 2; k++) begin
        int unsigned aw, mask, st, en, off, a;
        aw   = (k == 0) ? 4 : 10;
        mask = (32'd1 << aw) - 1;
        st   = $urandom & mask;
        off  = $urandom_range(0, 4);
        en   = (sw_mode == MODE_DOWN) ? ((st - off) & mask) : ((st + off) & mask);
        if (k == 0) begin s4 = 4'(st); e4 = 4'(en); end
        else        begin s10 = 10'(st); e10 = 10'(en); end
        len[k] = 0; idx[k] = 0; fin[k] = 1'b0;
        a = st;
        for (int s = 0; s < 6; s++) begin
          for (int r = 0; r <= int'(sw_dwell); r++) begin
            exp_seq[k][len[k]] = a;
            len[k]++;
          end
          if (sw_mode == MODE_SINGLE || a == en) break;
          a = (sw_mode == MODE_DOWN) ? ((a - 1) & mask) : ((a + 1) & mask);
        end
      end
      sw_valid = 1'b1;
      @(negedge clk);
      sw_valid = 1'b0;
      for (int c = 0; c < 40; c++) begin
        for (int k = 0; k < 2; k++) begin
          logic          av, ad;
          logic [9:0]    aa;
          logic [CW-1:0] ao, eo;
          string         tag;
          av  = (k == 0) ? v4 : v10;
          ad  = (k == 0) ? d4 : d10;
          aa  = (k == 0) ? 10'(a4) : a10;
          ao  = (k == 0) ? CW'(oh4) : oh10;
          tag = $sformatf("sweep%0d w%0d", n, (k == 0) ? 4 : 10);
          if (!fin[k]) begin
            eo = '0;
            if (idx[k] < len[k]) begin
              eo[exp_seq[k][idx[k]]] = 1'b1;
              chk({tag, " valid"}, CW'(av), CW'(1'b1));
              chk({tag, " addr"}, CW'(aa), CW'(exp_seq[k][idx[k]]));
              chk({tag, " onehot"}, ao, eo);
              chk({tag, " popcount"}, CW'($countones(ao)), CW'(av));
              idx[k]++;
            end else begin
              chk({tag, " done"}, CW'(ad), CW'(1'b1));
              chk({tag, " end valid"}, CW'(av), CW'(1'b0));
              chk({tag, " end onehot"}, ao, eo);
              fin[k] = 1'b1;
            end
          end
        end
        @(negedge clk);
        if (fin[0] && fin[1]) break;
      end
      chk($sformatf("sweep%0d completion bound", n), CW'(fin[0] && fin[1]), CW'(1'b1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
